// File: rtl/div_pkg.sv
// div_pkg: shared constants for the multi-cycle divider.
//   - FSM state encodings (DivFree/DivByZero/DivOn/DivEnd)
//   - start/stop and ready/not-ready levels
//   - operand width and the double-width result bus width
package div_pkg;

  localparam int DivDataW     = 32;
  localparam int DoubleRegBus = 2 * DivDataW;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_if.sv
// div_if: execute <-> divider handshake.
//   signed_div_i, opdata1_i, opdata2_i, start_i, annul_i : execute -> divider
//   result_o {remainder, quotient}, ready_o             : divider -> execute
// master = execute side, slave = divider side.
interface div_if
  import div_pkg::*;
#(
  parameter int DATA_W = DivDataW
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_abs.sv
// div_abs: combinational conditional two's-complement negate.
//   a   : input value
//   neg : 1 = output -a, 0 = pass a through
//   y   : result
// Used both for operand absolute values and for result sign fixes.
module div_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~a + 1'b1) : a;
endmodule

// File: rtl/div.sv
// div: 32-bit radix-2 restoring divider for DIV/DIVU, one quotient bit
// per clock.
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_if.slave (operands, start/annul in; result/ready out)
// result_o = {remainder, quotient}. Remainder takes the dividend's sign,
// quotient is negated when the operand signs differ (signed mode only).
// Optional build macro DIV_ZERO_DIVIDEND_EN: a zero dividend with a
// nonzero divisor short-cuts through the BYZERO path (result 0, 2 cycles).
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DivDataW,
  parameter int CNT_W  = 6
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W);

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  // {partial remainder, dividend/quotient bits}; one spare bit on top so the
  // shifted-out remainder survives the last shift.
  logic [2*DATA_W:0]   work;
  logic [DATA_W-1:0]   dvsr;
  logic                neg_q;
  logic                neg_r;

  logic [DATA_W-1:0]   op1_abs;
  logic [DATA_W-1:0]   op2_abs;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W:0]     diff;
  logic                take_zero;
  logic                op1_neg;
  logic                op2_neg;

  assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];

  div_abs #(.W(DATA_W)) u_abs_op1 (.a(bus.opdata1_i), .neg(op1_neg), .y(op1_abs));
  div_abs #(.W(DATA_W)) u_abs_op2 (.a(bus.opdata2_i), .neg(op2_neg), .y(op2_abs));
  div_abs #(.W(DATA_W)) u_fix_quo (.a(work[DATA_W-1:0]),          .neg(neg_q), .y(quot_fix));
  div_abs #(.W(DATA_W)) u_fix_rem (.a(work[2*DATA_W:DATA_W+1]),   .neg(neg_r), .y(rem_fix));

  // Extra top bit is the borrow: set means the divisor did not fit.
  assign diff = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, dvsr};

`ifdef DIV_ZERO_DIVIDEND_EN
  assign take_zero = (bus.opdata2_i == '0) || (bus.opdata1_i == '0);
`else
  assign take_zero = (bus.opdata2_i == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DivFree;
      cnt          <= '0;
      work         <= '0;
      dvsr         <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      bus.ready_o  <= DivResultNotReady;
      bus.result_o <= '0;
    end else begin
      case (state)
        DivFree: begin
          if (bus.start_i == DivStart && !bus.annul_i) begin
            if (take_zero) begin
              state <= DivByZero;
            end else begin
              state <= DivOn;
              cnt   <= '0;
              work  <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
              dvsr  <= op2_abs;
              // Signs captured now: operands may change once we leave FREE.
              neg_q <= op1_neg ^ op2_neg;
              neg_r <= op1_neg;
            end
          end
        end
        DivByZero: begin
          state        <= DivEnd;
          bus.result_o <= '0;
          bus.ready_o  <= DivResultReady;
        end
        DivOn: begin
          if (bus.annul_i) begin
            state        <= DivFree;
            cnt          <= '0;
            bus.ready_o  <= DivResultNotReady;
            bus.result_o <= '0;
          end else if (cnt != CntLast) begin
            if (diff[DATA_W])
              work <= {work[2*DATA_W-1:0], 1'b0};
            else
              work <= {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
            cnt <= cnt + 1'b1;
          end else begin
            state        <= DivEnd;
            cnt          <= '0;
            bus.result_o <= {rem_fix, quot_fix};
            bus.ready_o  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (bus.start_i == DivStop) begin
            state        <= DivFree;
            bus.ready_o  <= DivResultNotReady;
            bus.result_o <= '0;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: randomized self-checking bench for div against a plain-arithmetic
// reference (native / and % on 64-bit integers, zero divisor -> 0).
// Checks latency, result, hold-while-start, clear-on-drop, annul and reset.
module tb_div;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  div_if #(.DATA_W(32)) bus ();

  div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic int lat(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_ZERO_DIVIDEND_EN
    if (a == 32'd0) return 2;
`else
    if (a == 32'd0) return 34;
`endif
    return 34;
  endfunction

  // Starts at a negedge (cycle 0), scrambles operands once latched, then
  // checks latency, result, hold while start stays high, and clear on drop.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    int          cyc;
    logic [63:0] exp;
    exp = model(s, a, b);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = 1'($urandom);
      if (bus.ready_o) break;
    end
    chk("latency", 64'(cyc), 64'(lat(a, b)));
    chk("result", bus.result_o, exp);
    @(negedge clk);
    chk("hold_ready", 64'(bus.ready_o), 64'd1);
    chk("hold_result", bus.result_o, exp);
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("clr_ready", 64'(bus.ready_o), 64'd0);
    chk("clr_result", bus.result_o, 64'd0);
  endtask

  initial begin
    logic        seen;
    logic [31:0] a, b;
    logic        s;

    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(bus.ready_o), 64'd0);

    // Directed vectors.
    run_op(1'b0, 32'd100, 32'd7);
    run_op(1'b1, 32'hFFFFFFF9, 32'h00000002);
    run_op(1'b0, 32'hFFFFFFF9, 32'h00000002);
    run_op(1'b1, 32'h00001234, 32'h0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
    run_op(1'b0, 32'h0, 32'h5);
    run_op(1'b1, 32'h0, 32'hFFFFFFF0);

    // Annul in the middle of an operation.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o) seen = 1'b1;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_result", bus.result_o, 64'd0);
    run_op(1'b0, 32'd9, 32'd3);

    // Reset in the middle of an operation.
    bus.opdata1_i = 32'hDEADBEEF;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    repeat (15) @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(bus.ready_o), 64'd0);
    chk("midrst_result", bus.result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(1'b0, 32'hFFFFFFFF, 32'h10);

    // Back-to-back: run_op leaves start low for exactly one cycle.
    run_op(1'b0, 32'd77, 32'd5);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       a = 32'd0;
        1:       a = 32'h80000000;
        default: a = $urandom;
      endcase
      run_op(s, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
